// File: rtl/channelizer_reload_ctrl_if.sv
// Bundled stream ports of the channelizer coefficient reload controller.
// The master modport is the controller's view; slave is the surrounding fabric.
interface channelizer_reload_ctrl_if #(
    parameter int COEF_W = 32,
    parameter int ADDR_W = 10
);
    logic [COEF_W-1:0] s_coef_tdata;
    logic              s_coef_tlast;
    logic              s_coef_tvalid;
    logic              s_coef_tready;

    logic [COEF_W-1:0] m_reload_tdata;
    logic              m_reload_tlast;
    logic              m_reload_tvalid;
    logic              m_reload_tready;

    logic              m_config_tvalid;
    logic              m_config_tready;

    logic              s_data_tvalid;
    logic              s_data_tready;
    logic              m_data_tvalid;
    logic              m_data_tready;

    logic              busy;
    logic [ADDR_W:0]   num_taps;
    logic              error_stb;

    modport master (
        input  s_coef_tdata, s_coef_tlast, s_coef_tvalid,
        output s_coef_tready,
        output m_reload_tdata, m_reload_tlast, m_reload_tvalid,
        input  m_reload_tready,
        output m_config_tvalid,
        input  m_config_tready,
        input  s_data_tvalid,
        output s_data_tready,
        output m_data_tvalid,
        input  m_data_tready,
        output busy, num_taps, error_stb
    );

    modport slave (
        output s_coef_tdata, s_coef_tlast, s_coef_tvalid,
        input  s_coef_tready,
        input  m_reload_tdata, m_reload_tlast, m_reload_tvalid,
        output m_reload_tready,
        input  m_config_tvalid,
        output m_config_tready,
        output s_data_tvalid,
        input  s_data_tready,
        input  m_data_tvalid,
        output m_data_tready,
        input  busy, num_taps, error_stb
    );
endinterface

// File: rtl/channelizer_reload_ctrl.sv
// Buffers a polyphase FIR coefficient set, gates the sample stream, bursts the
// set onto the FIR reload port and commits it, then reopens the sample gate.
module channelizer_reload_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int COEF_W       = 32,
    parameter int FLUSH_CYCLES = 16
) (
    input logic                        ce_clk,
    input logic                        ce_rst,
    channelizer_reload_ctrl_if.master  bus
);

    typedef enum logic [1:0] {LOAD, FLUSH, RELOAD, CONFIG} state_t;

    localparam int              DEPTH_INT = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W:0]   final_q, final_d;
    logic [7:0]        flush_q, flush_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [COEF_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic              skid_last_q, skid_last_d;
    logic [COEF_W-1:0] skid_data_q, skid_data_d;
    logic [ADDR_W:0]   num_taps_q, num_taps_d;
    logic              error_stb_q, error_stb_d;
    logic              busy_q, busy_d;

    logic [COEF_W-1:0] mem [DEPTH_INT];
    logic [COEF_W-1:0] ram_rd_data;

    logic              coef_hs;
    logic              wr_en;
    logic              ovf_now;
    logic              reload_pop;
    logic              rd_issue;
    logic [1:0]        occ_after;
    logic              gate_open;

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state_q      <= LOAD;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            final_q      <= '0;
            flush_q      <= '0;
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            num_taps_q   <= '0;
            error_stb_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            final_q      <= final_d;
            flush_q      <= flush_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            num_taps_q   <= num_taps_d;
            error_stb_q  <= error_stb_d;
            busy_q       <= busy_d;
        end
    end

    // Coefficient buffer: plain synchronous RAM, one write and one read port.
    always_ff @(posedge ce_clk) begin
        if (wr_en) begin
            mem[count_q[ADDR_W-1:0]] <= bus.s_coef_tdata;
        end
        if (rd_issue) begin
            ram_rd_data <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    always_comb begin
        coef_hs    = bus.s_coef_tvalid && (state_q == LOAD);
        wr_en      = coef_hs && (count_q != DEPTH);
        ovf_now    = ovf_q || (count_q == DEPTH);
        reload_pop = out_valid_q && bus.m_reload_tready;
        // A read issued now lands one cycle later, so it may only go out if the
        // two-entry output stage is guaranteed a free slot even with no pop.
        occ_after  = 2'({1'b0, out_valid_q}) + 2'({1'b0, skid_valid_q})
                   + 2'({1'b0, rd_valid_q}) - 2'({1'b0, reload_pop});
        rd_issue   = (state_q == RELOAD) && (rd_ptr_q < final_q) && (occ_after <= 2'd1);

        state_d      = state_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        final_d      = final_q;
        flush_d      = flush_q;
        rd_ptr_d     = rd_ptr_q;
        num_taps_d   = num_taps_q;
        error_stb_d  = 1'b0;
        rd_valid_d   = rd_issue;
        rd_last_d    = rd_issue && (rd_ptr_q == final_q - 1'b1);
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;

        if (reload_pop) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                skid_valid_d = rd_valid_q;
                skid_last_d  = rd_last_q;
                skid_data_d  = ram_rd_data;
            end else begin
                out_valid_d  = rd_valid_q;
                out_last_d   = rd_last_q;
                out_data_d   = ram_rd_data;
            end
        end else if (rd_valid_q) begin
            if (!out_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = rd_last_q;
                out_data_d   = ram_rd_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_last_d  = rd_last_q;
                skid_data_d  = ram_rd_data;
            end
        end

        case (state_q)
            LOAD: begin
                if (coef_hs) begin
                    if (bus.s_coef_tlast && ovf_now) begin
                        error_stb_d = 1'b1;
                        count_d     = '0;
                        ovf_d       = 1'b0;
                    end else if (bus.s_coef_tlast) begin
                        count_d = count_q + 1'b1;
                        final_d = count_q + 1'b1;
                        flush_d = 8'(FLUSH_CYCLES);
                        state_d = FLUSH;
                    end else if (count_q != DEPTH) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (flush_q == 8'd0) begin
                    rd_ptr_d = '0;
                    state_d  = RELOAD;
                end else begin
                    flush_d = flush_q - 8'd1;
                end
            end
            RELOAD: begin
                if (rd_issue) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                if (reload_pop && out_last_q) begin
                    state_d = CONFIG;
                end
            end
            CONFIG: begin
                if (bus.m_config_tready) begin
                    num_taps_d = final_q;
                    count_d    = '0;
                    state_d    = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        busy_d = (state_d != LOAD);
    end

    always_comb begin
        gate_open           = (state_q == LOAD);
        bus.s_coef_tready   = gate_open;
        bus.m_data_tvalid   = bus.s_data_tvalid && gate_open;
        bus.s_data_tready   = bus.m_data_tready && gate_open;
        bus.m_config_tvalid = (state_q == CONFIG);
        bus.m_reload_tvalid = out_valid_q;
        bus.m_reload_tlast  = out_last_q;
        bus.m_reload_tdata  = out_data_q;
        bus.busy            = busy_q;
        bus.num_taps        = num_taps_q;
        bus.error_stb       = error_stb_q;
    end

endmodule

// File: doc/channelizer_reload_ctrl.md
Name: channelizer_reload_ctrl

Overview:
- Sequences a polyphase FIR coefficient reload for the channelizer without corrupting in-flight samples.
- Buffers coefficient words arriving from the settings-register AXI stream (SR_RELOAD / SR_RELOAD_LAST).
- On the last word it gates the sample stream, waits for the pipeline to quiesce, bursts the buffer onto the FIR reload port, issues the config commit, then reopens the sample gate.
- Sits between the axi_setting_reg coefficient FIFO / axi_wrapper sample output and channelizer_top.

Parameters:
ADDR_W, 10, log2 of coefficient buffer depth (1024 words)
COEF_W, 32, coefficient word width
FLUSH_CYCLES, 16, idle cycles after gate closes before reload starts (range 1..255)

Ports:
ce_clk  in  1  clock
ce_rst  in  1  asynchronous active-high reset
s_coef_tdata  in  COEF_W  coefficient word from settings FIFO
s_coef_tlast  in  1  last coefficient of set
s_coef_tvalid  in  1  coefficient valid
s_coef_tready  out  1  coefficient accept
m_reload_tdata  out  COEF_W  FIR reload word
m_reload_tlast  out  1  last reload word
m_reload_tvalid  out  1  reload valid
m_reload_tready  in  1  reload accept
m_config_tvalid  out  1  FIR config commit request
m_config_tready  in  1  config commit accept
s_data_tvalid  in  1  sample valid from axi_wrapper
s_data_tready  out  1  sample ready to axi_wrapper
m_data_tvalid  out  1  sample valid to channelizer
m_data_tready  in  1  sample ready from channelizer
busy  out  1  high in any state other than LOAD
num_taps  out  ADDR_W+1  word count of last committed set (readback)
error_stb  out  1  one-cycle pulse on overflow or empty set

Behaviour:
- Reset values: FSM=LOAD, write count 0, read pointer 0, m_reload_tvalid 0, m_reload_tlast 0, m_config_tvalid 0, error_stb 0, num_taps 0, gate open, busy 0.
- Gate: m_data_tvalid = s_data_tvalid & gate_open; s_data_tready = m_data_tready & gate_open. Purely combinational (zero latency). tdata is routed externally.
- gate_open = 1 only in LOAD.
- s_coef_tready = 1 only in LOAD.
- LOAD:
  - Each s_coef handshake writes the word at address count and increments count.
  - count saturates at 2^ADDR_W. Words beyond depth are accepted and dropped, and an overflow flag is set.
  - Handshake with tlast and overflow flag set: pulse error_stb, clear count and flag, stay in LOAD. The set is discarded and no reload occurs.
  - Handshake with tlast and no overflow: latch the final count (including this word), go to FLUSH.
  - A single-word set is legal.
- FLUSH:
  - Gate is closed. A down-counter loaded with FLUSH_CYCLES decrements every cycle.
  - At 0, go to RELOAD with read pointer 0.
  - A sample handshake already in progress in the closing cycle is not blocked, because the gate is combinational on state.
- RELOAD:
  - Buffer read latency is 1 cycle. m_reload_tvalid rises the 2nd cycle after entry.
  - Output stage is a registered skid. tdata and tlast are held stable while tvalid & !tready.
  - Words are emitted in write order, 0..count-1. tlast is asserted on word count-1 only.
  - Full throughput of 1 word/cycle while tready is high.
  - After the tlast handshake, tvalid drops the next cycle and the FSM goes to CONFIG.
- CONFIG:
  - m_config_tvalid = 1 until the m_config_tready handshake.
  - On handshake: num_taps <= latched count, count cleared, go to LOAD.
- busy = (state != LOAD), registered with state.
- Boundaries:
  - Coefficient words presented outside LOAD stall (tready 0). They are not lost.
  - tlast arriving exactly on word 2^ADDR_W is not an overflow.
  - m_config_tready held high continuously gives a one-cycle CONFIG.
  - Reset asserted in any state aborts immediately: outputs return to reset values, the partial set is discarded, and the gate reopens.

Test Plan:
- 8-word set 0x100..0x107 with tlast on the 8th, FLUSH_CYCLES=16, all readies high -> no sample transfers for 16+ cycles, m_reload emits 0x100..0x107 with tlast only on 0x107, one config handshake, num_taps=8, gate reopens, busy low.
- Same set with m_reload_tready toggling 1-0-1-0 -> identical word order, data/tlast stable during stalls, exactly 8 handshakes.
- 1025 words with tlast on the 1025th, ADDR_W=10 -> error_stb single pulse, no m_reload_tvalid, num_taps unchanged, next 4-word set reloads correctly.
- Exactly 1024 words -> no error, 1024 reload words with tlast on the last, num_taps=1024.
- Continuous samples with s_data_tvalid=1 during reload -> s_data_tready=0 from FLUSH entry until the cycle after the config handshake, zero samples reach m_data.
- ce_rst pulsed mid-RELOAD after 3 of 8 words -> m_reload_tvalid=0 immediately, busy=0, gate open, a subsequent full set completes normally.
